// File: rtl/clock_period_meter_if.sv
// Signal bundle between the period meter and whoever drives/observes it.
// Result handshake: period_valid is a one-cycle strobe with no ready; period and high_time are held stable between strobes.
`timescale 1ns/1ps
interface clock_period_meter_if #(
    parameter int WIDTH = 32
);
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             period_valid;
    logic             stalled;
    logic             state_dbg;

    modport master (
        output sig_in,
        input  period,
        input  high_time,
        input  period_valid,
        input  stalled,
        input  state_dbg
    );

    modport slave (
        input  sig_in,
        output period,
        output high_time,
        output period_valid,
        output stalled,
        output state_dbg
    );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in cycles,
// and flags a stall when no rising edge arrives within TIMEOUT cycles.
`timescale 1ns/1ps
module clock_period_meter #(
    parameter int          WIDTH   = 32,
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic                 clk_in,
    input  logic                 reset,
    clock_period_meter_if.slave  bus
);
    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic             r_s1, r_s2, r_s3;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hi_lat, w_hi_lat_nxt;
    logic [WIDTH-1:0] r_period, w_period_nxt;
    logic [WIDTH-1:0] r_high, w_high_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_stalled, w_stalled_nxt;
    logic             w_rise, w_fall;
    logic [WIDTH-1:0] w_cnt_inc;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_cnt_inc = r_cnt + WIDTH'(1);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_state   <= WAIT_FIRST;
            r_cnt     <= '0;
            r_hi_lat  <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_s1      <= bus.sig_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi_lat  <= w_hi_lat_nxt;
            r_period  <= w_period_nxt;
            r_high    <= w_high_nxt;
            r_valid   <= w_valid_nxt;
            r_stalled <= w_stalled_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_lat_nxt  = r_hi_lat;
        w_period_nxt  = r_period;
        w_high_nxt    = r_high;
        w_valid_nxt   = 1'b0;
        w_stalled_nxt = r_stalled;
        case (r_state)
            WAIT_FIRST: begin
                // Counter is parked at zero here so a stuck input can never wrap it.
                if (w_rise) begin
                    w_state_nxt   = MEASURE;
                    w_cnt_nxt     = '0;
                    w_stalled_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (w_fall) w_hi_lat_nxt = w_cnt_inc;
                // A rise coinciding with the timeout still counts as a valid period.
                if (w_rise) begin
                    w_period_nxt = w_cnt_inc;
                    w_high_nxt   = r_hi_lat;
                    w_valid_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stalled_nxt = 1'b1;
                    w_state_nxt   = WAIT_FIRST;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = WAIT_FIRST;
        endcase
    end

    assign bus.period       = r_period;
    assign bus.high_time    = r_high;
    assign bus.period_valid = r_valid;
    assign bus.stalled      = r_stalled;
    assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized bench for clock_period_meter against an edge-index reference model.
`timescale 1ns/1ps
module tb_clock_period_meter;
    localparam int W       = 16;
    localparam int TIMEOUT = 20;

    logic clk_in;
    logic reset;

    clock_period_meter_if #(.WIDTH(W)) ifc ();

    clock_period_meter #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (ifc)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model, in terms of sample-edge indices since reset release
    bit          samp_q[$];
    logic [W*2-1:0] exp_q[$];
    int          n_edge;
    bit          m_meas;
    int          m_k0;
    int          m_hl;
    logic [W-1:0] m_period, m_high;
    bit          m_valid, m_stalled;

    task automatic model_reset();
        samp_q.delete();
        exp_q.delete();
        n_edge    = 0;
        m_meas    = 1'b0;
        m_k0      = 0;
        m_hl      = 0;
        m_period  = '0;
        m_high    = '0;
        m_valid   = 1'b0;
        m_stalled = 1'b0;
    endtask

    task automatic model_step(input bit sample);
        int k;
        bit cur, prv;
        samp_q.push_back(sample);
        m_valid = 1'b0;
        // a sample taken at edge k first shows on the outputs after edge k+2
        if (n_edge >= 2) begin
            k   = n_edge - 2;
            cur = samp_q[k];
            prv = (k == 0) ? 1'b0 : samp_q[k-1];
            if (cur && !prv) begin
                if (m_meas) begin
                    m_period = W'(k - m_k0);
                    m_high   = W'(m_hl);
                    m_valid  = 1'b1;
                    exp_q.push_back({m_period, m_high});
                end
                m_meas    = 1'b1;
                m_stalled = 1'b0;
                m_k0      = k;
            end else begin
                if (!cur && prv && m_meas) m_hl = k - m_k0;
                if (m_meas && (k - m_k0 == TIMEOUT)) begin
                    m_stalled = 1'b1;
                    m_meas    = 1'b0;
                end
            end
        end
        n_edge++;
    endtask

    // monitor + scoreboard
    initial begin
        logic [W*2-1:0] e;
        model_reset();
        forever begin
            @(posedge clk_in);
            if (!reset) begin
                model_reset();
            end else begin
                model_step(ifc.sig_in);
                #1;
                if (reset) begin
                    check("period_valid", ifc.period_valid, m_valid);
                    check("stalled", ifc.stalled, m_stalled);
                    check("period", ifc.period, m_period);
                    check("high_time", ifc.high_time, m_high);
                    check("state_dbg", ifc.state_dbg, m_meas);
                    if (ifc.period_valid) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_strobe", ifc.period_valid, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("sb_period", ifc.period, e[W*2-1:W]);
                            check("sb_high", ifc.high_time, e[W-1:0]);
                        end
                    end
                end
            end
        end
    end

    // driver tasks (inputs change on the falling edge)
    task automatic drive_level(input bit v, input int cycles);
        ifc.sig_in = v;
        repeat (cycles) @(negedge clk_in);
    endtask

    task automatic square(input int hi, input int lo, input int periods);
        for (int i = 0; i < periods; i++) begin
            drive_level(1'b1, hi);
            drive_level(1'b0, lo);
        end
    endtask

    task automatic apply_reset(input bit level, input int hold);
        @(negedge clk_in);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_period", ifc.period, 0);
        check("rst_high_time", ifc.high_time, 0);
        check("rst_period_valid", ifc.period_valid, 0);
        check("rst_stalled", ifc.stalled, 0);
        ifc.sig_in = level;
        repeat (hold) @(negedge clk_in);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        ifc.sig_in = 1'b0;
        apply_reset(1'b0, 3);

        square(4, 4, 6);
        square(3, 7, 5);
        square(1, 4, 5);
        for (int i = 0; i < 25; i++)
            square($urandom_range(1, 9), $urandom_range(1, 9), 1);

        // stall and recovery
        square(4, 4, 2);
        drive_level(1'b0, 30);
        check("stall_hold_stalled", ifc.stalled, 1);
        check("stall_hold_period", ifc.period, 8);
        square(4, 4, 3);

        // period equal to TIMEOUT (rise wins), then one cycle longer (stall)
        square(10, 10, 3);
        square(10, 11, 3);

        // reset in the middle of a measurement
        square(4, 4, 2);
        drive_level(1'b1, 2);
        apply_reset(1'b0, 3);
        square(4, 4, 3);

        for (int i = 0; i < 25; i++)
            square($urandom_range(1, 12), $urandom_range(1, 14), 1);

        // constant high from reset
        apply_reset(1'b1, 2);
        drive_level(1'b1, 40);
        check("const_high_stalled", ifc.stalled, 1);
        check("const_high_period", ifc.period, 0);
        check("const_high_valid", ifc.period_valid, 0);

        drive_level(1'b0, 4);
        check("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
